// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared encodings for the multicycle MIPS main control FSM
package mips_ctrl_pkg;

   // FSM state codes; the numeric values are visible on the debug state port
   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      EXECUTE = 4'd6,
      ALUWB   = 4'd7,
      BRANCH  = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JUMP    = 4'd11
   } state_t;

   // Numeric state codes for code that works on plain vectors
   localparam logic [3:0] ST_FETCH   = 4'd0;
   localparam logic [3:0] ST_DECODE  = 4'd1;
   localparam logic [3:0] ST_MEMADR  = 4'd2;
   localparam logic [3:0] ST_MEMRD   = 4'd3;
   localparam logic [3:0] ST_MEMWB   = 4'd4;
   localparam logic [3:0] ST_MEMWR   = 4'd5;
   localparam logic [3:0] ST_EXECUTE = 4'd6;
   localparam logic [3:0] ST_ALUWB   = 4'd7;
   localparam logic [3:0] ST_BRANCH  = 4'd8;
   localparam logic [3:0] ST_ADDIEX  = 4'd9;
   localparam logic [3:0] ST_ADDIWB  = 4'd10;
   localparam logic [3:0] ST_JUMP    = 4'd11;

   // instr[31:26] values of the supported instructions
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   // alu_op as understood by the downstream ALU control decoder
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // PC source mux
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // ALU B operand mux
   localparam logic [1:0] SRCB_REG     = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   // Full control word produced by the state decoder. pc_write and branch
   // stay internal; the top folds them into the single pc_en.
   typedef struct packed {
      logic       iord;
      logic       mem_write;
      logic       ir_write;
      logic       pc_write;
      logic       branch;
      logic [1:0] pc_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
   } ctrl_word_t;

   localparam ctrl_word_t CTRL_IDLE = '0;

endpackage

// File: rtl/multicycle_main_control_if.sv
// rtl/multicycle_main_control_if.sv - controller <-> datapath bundle (mem_ready only with MC_MEM_WAIT_EN)
interface multicycle_main_control_if;
   // datapath status into the controller
   logic [5:0] opcode;
   logic       zero;
`ifdef MC_MEM_WAIT_EN
   logic       mem_ready;
`endif
   // controls out to the datapath
   logic       iord;
   logic       mem_write;
   logic       ir_write;
   logic       pc_en;
   logic [1:0] pc_src;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic       reg_write;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       illegal_op;

`ifdef MC_MEM_WAIT_EN
   modport master (
      input  opcode, zero, mem_ready,
      output iord, mem_write, ir_write, pc_en, pc_src, alu_src_a, alu_src_b,
             alu_op, reg_write, reg_dst, mem_to_reg, illegal_op
   );
   modport slave (
      output opcode, zero, mem_ready,
      input  iord, mem_write, ir_write, pc_en, pc_src, alu_src_a, alu_src_b,
             alu_op, reg_write, reg_dst, mem_to_reg, illegal_op
   );
`else
   modport master (
      input  opcode, zero,
      output iord, mem_write, ir_write, pc_en, pc_src, alu_src_a, alu_src_b,
             alu_op, reg_write, reg_dst, mem_to_reg, illegal_op
   );
   modport slave (
      output opcode, zero,
      input  iord, mem_write, ir_write, pc_en, pc_src, alu_src_a, alu_src_b,
             alu_op, reg_write, reg_dst, mem_to_reg, illegal_op
   );
`endif
endinterface

// File: rtl/mc_ctrl_decode.sv
// rtl/mc_ctrl_decode.sv - combinational state to control word decoder
module mc_ctrl_decode
   import mips_ctrl_pkg::*;
(
   input  state_t     state,
   input  logic       mem_ready,
   output ctrl_word_t cw
);

   // Moore decode: every field defaults to 0, each state raises only its own controls
   always_comb begin
      cw = CTRL_IDLE;
      case (state)
         FETCH: begin
            cw.iord      = 1'b0;
            cw.alu_src_a = 1'b0;
            cw.alu_src_b = SRCB_FOUR;
            cw.alu_op    = ALUOP_ADD;
            cw.pc_src    = PCSRC_ALU;
            // IR load and PC+4 only happen on the cycle memory returns data,
            // so a stalled fetch advances the PC exactly once
            cw.ir_write  = mem_ready;
            cw.pc_write  = mem_ready;
         end
         DECODE: begin
            // speculative branch target PC + (imm << 2) into ALUOut
            cw.alu_src_a = 1'b0;
            cw.alu_src_b = SRCB_IMM_SH2;
            cw.alu_op    = ALUOP_ADD;
         end
         MEMADR: begin
            cw.alu_src_a = 1'b1;
            cw.alu_src_b = SRCB_IMM;
            cw.alu_op    = ALUOP_ADD;
         end
         MEMRD: begin
            cw.iord = 1'b1;
         end
         MEMWB: begin
            cw.reg_dst    = 1'b0;
            cw.mem_to_reg = 1'b1;
            cw.reg_write  = 1'b1;
         end
         MEMWR: begin
            // held through any wait so the store address and strobe stay valid
            cw.iord      = 1'b1;
            cw.mem_write = 1'b1;
         end
         EXECUTE: begin
            cw.alu_src_a = 1'b1;
            cw.alu_src_b = SRCB_REG;
            cw.alu_op    = ALUOP_FUNCT;
         end
         ALUWB: begin
            cw.reg_dst    = 1'b1;
            cw.mem_to_reg = 1'b0;
            cw.reg_write  = 1'b1;
         end
         BRANCH: begin
            cw.alu_src_a = 1'b1;
            cw.alu_src_b = SRCB_REG;
            cw.alu_op    = ALUOP_SUB;
            cw.pc_src    = PCSRC_ALUOUT;
            cw.branch    = 1'b1;
         end
         ADDIEX: begin
            cw.alu_src_a = 1'b1;
            cw.alu_src_b = SRCB_IMM;
            cw.alu_op    = ALUOP_ADD;
         end
         ADDIWB: begin
            cw.reg_dst    = 1'b0;
            cw.mem_to_reg = 1'b0;
            cw.reg_write  = 1'b1;
         end
         JUMP: begin
            cw.pc_src   = PCSRC_JUMP;
            cw.pc_write = 1'b1;
         end
         default: cw = CTRL_IDLE;
      endcase
   end

endmodule

// File: rtl/multicycle_main_control.sv
// rtl/multicycle_main_control.sv - multicycle MIPS main control FSM (optional memory wait: MC_MEM_WAIT_EN)
module multicycle_main_control
   import mips_ctrl_pkg::*;
#(
   parameter int STATE_W = 4
)
(
   input  logic                        clk,
   input  logic                        rst_n,
   multicycle_main_control_if.master   bus,
   output logic [STATE_W-1:0]          state
);

   state_t     state_q;
   logic       illegal_q;
   logic       mem_ready;
   ctrl_word_t cw;
   ctrl_word_t cw_out;

`ifdef MC_MEM_WAIT_EN
   assign mem_ready = bus.mem_ready;
`else
   // without the wait handshake memory always completes in one cycle
   assign mem_ready = 1'b1;
`endif

   // State register, next-state selection and sticky illegal-opcode flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= FETCH;
         illegal_q <= 1'b0;
      end else begin
         case (state_q)
            FETCH: begin
               if (mem_ready)
                  state_q <= DECODE;
            end
            DECODE: begin
               case (bus.opcode)
                  OP_LW, OP_SW: state_q <= MEMADR;
                  OP_RTYPE:     state_q <= EXECUTE;
                  OP_BEQ:       state_q <= BRANCH;
                  OP_ADDI:      state_q <= ADDIEX;
                  OP_J:         state_q <= JUMP;
                  default: begin
                     // drop the instruction and flag it until the next reset
                     state_q   <= FETCH;
                     illegal_q <= 1'b1;
                  end
               endcase
            end
            MEMADR: begin
               // only lw and sw reach here, so anything but sw is a load
               if (bus.opcode == OP_SW)
                  state_q <= MEMWR;
               else
                  state_q <= MEMRD;
            end
            MEMRD: begin
               if (mem_ready)
                  state_q <= MEMWB;
            end
            MEMWR: begin
               if (mem_ready)
                  state_q <= FETCH;
            end
            EXECUTE: state_q <= ALUWB;
            ADDIEX:  state_q <= ADDIWB;
            MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: state_q <= FETCH;
            default: state_q <= FETCH;
         endcase
      end
   end

   mc_ctrl_decode u_decode (
      .state     (state_q),
      .mem_ready (mem_ready),
      .cw        (cw)
   );

   // Reset gates every control directly so an instruction aborted by
   // reset cannot issue a write while rst_n is low
   always_comb begin
      cw_out = CTRL_IDLE;
      if (rst_n)
         cw_out = cw;
   end

   assign bus.iord       = cw_out.iord;
   assign bus.mem_write  = cw_out.mem_write;
   assign bus.ir_write   = cw_out.ir_write;
   assign bus.pc_en      = cw_out.pc_write | (cw_out.branch & bus.zero);
   assign bus.pc_src     = cw_out.pc_src;
   assign bus.alu_src_a  = cw_out.alu_src_a;
   assign bus.alu_src_b  = cw_out.alu_src_b;
   assign bus.alu_op     = cw_out.alu_op;
   assign bus.reg_write  = cw_out.reg_write;
   assign bus.reg_dst    = cw_out.reg_dst;
   assign bus.mem_to_reg = cw_out.mem_to_reg;
   assign bus.illegal_op = illegal_q;

   assign state = STATE_W'(state_q);

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Main control FSM for the multicycle MIPS datapath. It sits directly upstream of the ALU control decoder.
- It sequences instruction fetch, decode, execute, memory access and write-back over multiple cycles.
- It drives all datapath enables and muxes, plus the 2-bit alu_op consumed by the ALU control decoder: 00 add, 01 subtract, 10 use funct.
- Supported instructions: R-type, lw, sw, beq, addi, j.

Parameters:
- STATE_W, 4, width of the state register and of the state debug output.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- opcode  input  6  instr[31:26] from the instruction register; stable from DECODE onward
- zero  input  1  ALU zero flag
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  output  1  memory write enable
- ir_write  output  1  instruction register load
- pc_en  output  1  PC load enable, equal to pc_write | (branch & zero)
- pc_src  output  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target
- alu_src_a  output  1  ALU A select: 0 = PC, 1 = register A
- alu_src_b  output  2  ALU B select: 00 register B, 01 constant 4, 10 sign-extended immediate, 11 sign-extended immediate << 2
- alu_op  output  2  to the ALU control decoder
- reg_write  output  1  register file write enable
- reg_dst  output  1  destination register select: 0 = rt, 1 = rd
- mem_to_reg  output  1  write-back select: 0 = ALUOut, 1 = MDR
- illegal_op  output  1  sticky unsupported-opcode flag
- state  output  STATE_W  current state (debug)

Behaviour:
- Reset:
  - Single clock domain. rst_n is asynchronous and active-low.
  - While rst_n = 0: state = FETCH (0), illegal_op = 0, and every other output is forced to 0, including ir_write and pc_en.
  - First FETCH outputs appear in the first cycle after rst_n rises.
  - Reset mid-instruction aborts the instruction immediately; no partial writes occur after the reset assertion.
- Moore FSM: outputs decode from state only. Exception: pc_en also depends combinationally on zero.
- Unlisted outputs are 0 in each state. State codes in parentheses.
  - FETCH (0): iord=0, src_a=0, src_b=01, alu_op=00, pc_src=00, ir_write=1, pc_write=1. Next: DECODE.
  - DECODE (1): src_a=0, src_b=11, alu_op=00 (branch target computed). Next state by opcode:
    - 100011 (lw) and 101011 (sw): MEMADR
    - 000000 (R-type): EXECUTE
    - 000100 (beq): BRANCH
    - 001000 (addi): ADDIEX
    - 000010 (j): JUMP
    - any other opcode: FETCH, and illegal_op is set to 1.
  - MEMADR (2): src_a=1, src_b=10, alu_op=00. Next: MEMRD for lw, MEMWR for sw.
  - MEMRD (3): iord=1. Next: MEMWB.
  - MEMWB (4): reg_dst=0, mem_to_reg=1, reg_write=1. Next: FETCH.
  - MEMWR (5): iord=1, mem_write=1. Next: FETCH.
  - EXECUTE (6): src_a=1, src_b=00, alu_op=10. Next: ALUWB.
  - ALUWB (7): reg_dst=1, mem_to_reg=0, reg_write=1. Next: FETCH.
  - BRANCH (8): src_a=1, src_b=00, alu_op=01, pc_src=01, branch=1. Next: FETCH.
  - ADDIEX (9): src_a=1, src_b=10, alu_op=00. Next: ADDIWB.
  - ADDIWB (10): reg_dst=0, mem_to_reg=0, reg_write=1. Next: FETCH.
  - JUMP (11): pc_src=10, pc_write=1. Next: FETCH.
  - Codes 12-15: all outputs 0. Next: FETCH.
- Instruction latency in cycles: lw 5; sw, R-type and addi 4; beq and j 3.
- pc_write and branch are internal signals only. pc_en is the single PC enable.
- illegal_op is cleared only by reset.

Optional Feature:
- Macro: MC_MEM_WAIT_EN.
- Defined:
  - Adds input port mem_ready (1 bit).
  - FETCH, MEMRD and MEMWR hold their state while mem_ready = 0.
  - In FETCH, ir_write and pc_en assert only in the cycle where mem_ready = 1, so the PC advances exactly once.
  - iord and mem_write stay asserted through the wait.
  - Each memory wait cycle adds 1 cycle to latency.
- Undefined: no mem_ready port; every state lasts exactly 1 cycle.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state code localparams
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J)
  - alu_op encodings (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT)
  - pc_src and alu_src_b encodings
- One natural sub-module: mc_ctrl_decode, a purely combinational state-to-control-word decoder. The top module keeps the state register and next-state logic.

Test Plan:
- Hold rst_n low 3 cycles → all outputs 0 and state = 0. Release → FETCH outputs: ir_write=1, pc_en=1, src_b=01.
- lw (opcode 100011) → states 0,1,2,3,4; reg_write=1 and mem_to_reg=1 in cycle 5; back to state 0.
- R-type (000000) → alu_op=10 in EXECUTE, reg_dst=1 in ALUWB; sw (101011) → mem_write=1 for exactly 1 cycle; 4 cycles each.
- beq with zero=1 → pc_en=1 and pc_src=01 in BRANCH. Repeat with zero=0 → pc_en=0. j → pc_en=1, pc_src=10.
- opcode 111111 → DECODE returns to FETCH and illegal_op=1 stays high. rst_n pulse mid-MEMRD → immediate return to state 0 and illegal_op cleared.
- With MC_MEM_WAIT_EN: mem_ready=0 for 2 cycles in FETCH → state holds and pc_en=0; pc_en pulses once when mem_ready=1. lw latency becomes 7 with 2 wait cycles.
